voice_scheduler: RTL and testbench

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

---
 rtl/audio_pkg.sv | 26 ++
 rtl/voice_scheduler_if.sv | 24 ++
 rtl/voice_table.sv | 82 ++++++++
 rtl/voice_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_voice_scheduler.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : audio_pkg                                                       |
// | Purpose  : Shared constants and the scheduler state encoding for the       |
// |            DDS voice scheduler slice.                                      |
// | Contents : NOTE_WDTH      - MIDI note number width                         |
// |            DDS_QUERY_LAT  - cycles between query_sine and a valid sine_in  |
// |            sched_state_t  - voice_scheduler FSM states                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package audio_pkg;

  localparam int NOTE_WDTH     = 7;
  localparam int DDS_QUERY_LAT = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALLOC = 3'd1,
    QUERY = 3'd2,
    WAIT  = 3'd3,
    ACCUM = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/voice_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: voice_scheduler_if                                              |
// | Purpose  : Note-event handshake into the voice scheduler.                  |
// | Signals  : note_valid - event offered (master)                             |
// |            note_ready - event accepted when valid && ready (slave)         |
// |            note_on    - 1 = note-on, 0 = note-off (master)                 |
// |            note       - MIDI note number (master)                          |
// | Modports : master (event source), slave (scheduler)                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface voice_scheduler_if;
  import audio_pkg::*;

  logic                 note_valid;
  logic                 note_ready;
  logic                 note_on;
  logic [NOTE_WDTH-1:0] note;

  modport master (output note_valid, output note_on, output note, input note_ready);
  modport slave  (input note_valid, input note_on, input note, output note_ready);

endinterface : voice_scheduler_if
`default_nettype wire

// File: rtl/voice_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : voice_table                                                     |
// | Purpose  : Per-voice active bits and note numbers, plus the lowest-index   |
// |            free-voice and note-match priority searches.                    |
// | Ports    : clk, rst        - clock, synchronous active-high reset          |
// |            load_en_i/idx/note - activate a voice and load its note         |
// |            clr_en_i/idx    - deactivate a voice                            |
// |            search_note_i   - note compared against active voices           |
// |            active_o        - active mask                                   |
// |            notes_o         - flat per-voice notes, voice v at [7v+6:7v]    |
// |            free_found_o/free_idx_o   - lowest inactive voice               |
// |            match_found_o/match_idx_o - lowest active voice == search note  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module voice_table
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2
) (
  input  wire logic                            clk,
  input  wire logic                            rst,
  input  wire logic                            load_en_i,
  input  wire logic [VIDX_W-1:0]               load_idx_i,
  input  wire logic [NOTE_WDTH-1:0]            load_note_i,
  input  wire logic                            clr_en_i,
  input  wire logic [VIDX_W-1:0]               clr_idx_i,
  input  wire logic [NOTE_WDTH-1:0]            search_note_i,
  output logic      [NUM_VOICES-1:0]           active_o,
  output logic      [NOTE_WDTH*NUM_VOICES-1:0] notes_o,
  output logic                                 free_found_o,
  output logic      [VIDX_W-1:0]               free_idx_o,
  output logic                                 match_found_o,
  output logic      [VIDX_W-1:0]               match_idx_o
);

  logic [NUM_VOICES-1:0] active_q;
  logic [NOTE_WDTH-1:0]  note_q [NUM_VOICES];

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) note_q[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (load_en_i && (load_idx_i == VIDX_W'(v))) begin
          active_q[v] <= 1'b1;
          note_q[v]   <= load_note_i;
        end else if (clr_en_i && (clr_idx_i == VIDX_W'(v))) begin
          active_q[v] <= 1'b0;
        end
      end
    end
  end

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    free_found_o  = 1'b0;
    free_idx_o    = '0;
    match_found_o = 1'b0;
    match_idx_o   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active_q[v]) begin
        free_found_o = 1'b1;
        free_idx_o   = VIDX_W'(v);
      end
      if (active_q[v] && (note_q[v] == search_note_i)) begin
        match_found_o = 1'b1;
        match_idx_o   = VIDX_W'(v);
      end
    end
  end

  assign active_o = active_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_notes
    assign notes_o[v*NOTE_WDTH +: NOTE_WDTH] = note_q[v];
  end

endmodule : voice_table
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : voice_scheduler                                                 |
// | Purpose  : Allocates DDS voices from note events and, on every sample      |
// |            tick, queries the active voices and sums their sines.           |
// | Ports    : clk, rst      - clock, synchronous active-high reset            |
// |            note_bus      - note event handshake (voice_scheduler_if.slave) |
// |            sample_tick   - sample-rate strobe                              |
// |            change_note   - one-hot per-voice load/retrigger pulse          |
// |            voice_note    - per-voice note, voice v at [7v+6:7v]            |
// |            query_sine    - per-voice phase-advance pulse                   |
// |            sine_in       - per-voice signed DDS sine                       |
// |            mix_out       - signed sum of active voices                     |
// |            mix_valid     - one-cycle pulse, mix_out updated                |
// |            overrun       - sticky, tick arrived while a mix was running    |
// |            note_drop     - one-cycle pulse, note-on discarded              |
// | Options  : VOICE_STEAL_EN - steal a voice round-robin when none is free    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module voice_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int DATA_WDTH  = 24
) (
  input  wire logic                                              clk,
  input  wire logic                                              rst,
  voice_scheduler_if.slave                                       note_bus,
  input  wire logic                                              sample_tick,
  output logic      [NUM_VOICES-1:0]                             change_note,
  output logic      [NOTE_WDTH*NUM_VOICES-1:0]                   voice_note,
  output logic      [NUM_VOICES-1:0]                             query_sine,
  input  wire logic [DATA_WDTH*NUM_VOICES-1:0]                   sine_in,
  output logic      [DATA_WDTH+$clog2(NUM_VOICES)-1:0]           mix_out,
  output logic                                                   mix_valid,
  output logic                                                   overrun,
  output logic                                                   note_drop
);

  localparam int MIX_WDTH = DATA_WDTH + $clog2(NUM_VOICES);
  localparam int VIDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WAIT_W   = (DDS_QUERY_LAT > 1) ? $clog2(DDS_QUERY_LAT) : 1;

  sched_state_t                 state_q;
  logic                         tick_pending_q;
  logic                         ev_on_q;
  logic [NOTE_WDTH-1:0]         ev_note_q;
  logic [WAIT_W-1:0]            wait_cnt_q;
  logic [VIDX_W-1:0]            acc_idx_q;
  logic signed [MIX_WDTH-1:0]   acc_q;
  logic signed [MIX_WDTH-1:0]   mix_out_q;
  logic                         mix_valid_q;
  logic [NUM_VOICES-1:0]        change_note_q;
  logic [NUM_VOICES-1:0]        query_sine_q;
  logic                         overrun_q;
  logic                         note_drop_q;
`ifdef VOICE_STEAL_EN
  logic [VIDX_W-1:0]            steal_ptr_q;
  logic                         steal_adv_d;
`endif

  logic [NUM_VOICES-1:0]        active;
  logic                         free_found;
  logic [VIDX_W-1:0]            free_idx;
  logic                         match_found;
  logic [VIDX_W-1:0]            match_idx;

  logic                         load_en_d;
  logic [VIDX_W-1:0]            load_idx_d;
  logic                         clr_en_d;
  logic [VIDX_W-1:0]            clr_idx_d;
  logic                         cn_en_d;
  logic [VIDX_W-1:0]            cn_idx_d;
  logic [NUM_VOICES-1:0]        cn_mask_d;
  logic                         drop_d;
  logic signed [MIX_WDTH-1:0]   term_d;
  logic signed [MIX_WDTH-1:0]   acc_d;

  logic signed [DATA_WDTH-1:0]  sine_arr [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_sine
    assign sine_arr[v] = sine_in[v*DATA_WDTH +: DATA_WDTH];
  end

  voice_table #(
    .NUM_VOICES (NUM_VOICES),
    .VIDX_W     (VIDX_W)
  ) u_voice_table (
    .clk           (clk),
    .rst           (rst),
    .load_en_i     (load_en_d),
    .load_idx_i    (load_idx_d),
    .load_note_i   (ev_note_q),
    .clr_en_i      (clr_en_d),
    .clr_idx_i     (clr_idx_d),
    .search_note_i (ev_note_q),
    .active_o      (active),
    .notes_o       (voice_note),
    .free_found_o  (free_found),
    .free_idx_o    (free_idx),
    .match_found_o (match_found),
    .match_idx_o   (match_idx)
  );

  // A tick offered in the same cycle as an event wins, so ready drops with it.
  assign note_bus.note_ready = (state_q == IDLE) && !tick_pending_q && !sample_tick;

  // Allocation decision, evaluated only during the single ALLOC cycle.
  always_comb begin
    load_en_d  = 1'b0;
    load_idx_d = '0;
    clr_en_d   = 1'b0;
    clr_idx_d  = '0;
    cn_en_d    = 1'b0;
    cn_idx_d   = '0;
    drop_d     = 1'b0;
`ifdef VOICE_STEAL_EN
    steal_adv_d = 1'b0;
`endif
    if (state_q == ALLOC) begin
      if (ev_on_q) begin
        if (match_found) begin
          cn_en_d  = 1'b1;
          cn_idx_d = match_idx;
        end else if (free_found) begin
          load_en_d  = 1'b1;
          load_idx_d = free_idx;
          cn_en_d    = 1'b1;
          cn_idx_d   = free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          load_en_d   = 1'b1;
          load_idx_d  = steal_ptr_q;
          cn_en_d     = 1'b1;
          cn_idx_d    = steal_ptr_q;
          steal_adv_d = 1'b1;
`else
          drop_d = 1'b1;
`endif
        end
      end else if (match_found) begin
        clr_en_d  = 1'b1;
        clr_idx_d = match_idx;
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      cn_mask_d[v] = cn_en_d && (cn_idx_d == VIDX_W'(v));
    end
  end

  // Inactive voices contribute zero; the cast sign-extends into the mix width.
  always_comb begin
    term_d = '0;
    if (active[acc_idx_q]) term_d = MIX_WDTH'(sine_arr[acc_idx_q]);
    acc_d = acc_q + term_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      tick_pending_q <= 1'b0;
      ev_on_q        <= 1'b0;
      ev_note_q      <= '0;
      wait_cnt_q     <= '0;
      acc_idx_q      <= '0;
      acc_q          <= '0;
      mix_out_q      <= '0;
      mix_valid_q    <= 1'b0;
      change_note_q  <= '0;
      query_sine_q   <= '0;
      overrun_q      <= 1'b0;
      note_drop_q    <= 1'b0;
`ifdef VOICE_STEAL_EN
      steal_ptr_q    <= '0;
`endif
    end else begin
      change_note_q <= '0;
      query_sine_q  <= '0;
      mix_valid_q   <= 1'b0;
      note_drop_q   <= 1'b0;

      // Ticks during ALLOC are deferred; ticks during a mix are lost.
      if (sample_tick) begin
        if (state_q == ALLOC) tick_pending_q <= 1'b1;
        else if (state_q inside {QUERY, WAIT, ACCUM, DONE}) overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (tick_pending_q || sample_tick) begin
            tick_pending_q <= 1'b0;
            query_sine_q   <= active;
            state_q        <= QUERY;
          end else if (note_bus.note_valid) begin
            ev_on_q   <= note_bus.note_on;
            ev_note_q <= note_bus.note;
            state_q   <= ALLOC;
          end
        end
        ALLOC: begin
          change_note_q <= cn_mask_d;
          note_drop_q   <= drop_d;
`ifdef VOICE_STEAL_EN
          if (steal_adv_d) begin
            steal_ptr_q <= (steal_ptr_q == VIDX_W'(NUM_VOICES - 1)) ? '0
                                                                     : steal_ptr_q + VIDX_W'(1);
          end
`endif
          state_q <= IDLE;
        end
        QUERY: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_W'(DDS_QUERY_LAT - 1)) begin
            acc_idx_q <= '0;
            acc_q     <= '0;
            state_q   <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q     <= acc_d;
          acc_idx_q <= acc_idx_q + VIDX_W'(1);
          // The final sum is registered on entry to DONE so mix_valid and the
          // new mix_out appear together in the DONE cycle.
          if (acc_idx_q == VIDX_W'(NUM_VOICES - 1)) begin
            mix_out_q   <= acc_d;
            mix_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign change_note = change_note_q;
  assign query_sine  = query_sine_q;
  assign mix_out     = mix_out_q;
  assign mix_valid   = mix_valid_q;
  assign overrun     = overrun_q;
  assign note_drop   = note_drop_q;

endmodule : voice_scheduler
`default_nettype wire

// File: tb/tb_voice_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_voice_scheduler                                              |
// | Purpose  : Scoreboard bench for voice_scheduler. Stimulus pushes expected  |
// |            change_note / note_drop / mix events; a monitor pops and        |
// |            compares whenever the DUT presents one.                         |
// | Options  : VOICE_STEAL_EN - expects a steal instead of a drop              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_voice_scheduler;
  import audio_pkg::*;

  localparam int N  = 4;
  localparam int DW = 24;
  localparam int MW = 26;

  localparam int K_MIX = 0;
  localparam int K_CHG = 1;
  localparam int K_DRP = 2;

  typedef struct {
    int kind;
    int val;
    int vidx;
    int note;
    int cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_tick = 1'b0;
  logic [N-1:0]       change_note;
  logic [7*N-1:0]     voice_note;
  logic [N-1:0]       query_sine;
  logic [DW*N-1:0]    sine_in = '0;
  logic [MW-1:0]      mix_out;
  logic               mix_valid;
  logic               overrun;
  logic               note_drop;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   tcyc  = 0;
  int   acc   = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  voice_scheduler_if nb ();

  voice_scheduler #(.NUM_VOICES(N), .DATA_WDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .note_bus    (nb.slave),
    .sample_tick (sample_tick),
    .change_note (change_note),
    .voice_note  (voice_note),
    .query_sine  (query_sine),
    .sine_in     (sine_in),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .overrun     (overrun),
    .note_drop   (note_drop)
  );

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int val, input int vidx, input int note, input int c);
    exp_t e;
    e.kind = kind; e.val = val; e.vidx = vidx; e.note = note; e.cyc = c;
    q.push_back(e);
  endtask

  // Monitor: every DUT output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mix_valid) begin
        if (q.size() == 0 || q[0].kind != K_MIX) begin
          chk("mix_unexpected", longint'($signed(mix_out)), -1);
        end else begin
          mon_e = q.pop_front();
          chk("mix_out", longint'($signed(mix_out)), mon_e.val);
          chk("mix_latency", cyc, mon_e.cyc);
        end
      end
      if (|change_note) begin
        if (q.size() == 0 || q[0].kind != K_CHG) begin
          chk("change_note_unexpected", change_note, 0);
        end else begin
          mon_e = q.pop_front();
          chk("change_note", change_note, mon_e.val);
          chk("voice_note", voice_note[mon_e.vidx*7 +: 7], mon_e.note);
        end
      end
      if (note_drop) begin
        if (q.size() == 0 || q[0].kind != K_DRP) begin
          chk("note_drop_unexpected", note_drop, 0);
        end else begin
          mon_e = q.pop_front();
          chk("note_drop", note_drop, 1);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(posedge clk);
  endtask

  task automatic set_sine(input int a, input int b, input int c, input int d);
    sine_in = {DW'(d), DW'(c), DW'(b), DW'(a)};
  endtask

  task automatic send_note(input bit on, input int n);
    int got;
    @(posedge clk); #1;
    nb.note_valid = 1'b1; nb.note_on = on; nb.note = 7'(n);
    got = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nb.note_ready) begin got = cyc; break; end
    end
    @(posedge clk); #1;
    nb.note_valid = 1'b0;
    if (got < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic note_chg(input bit on, input int n, input int v);
    push_exp(K_CHG, 1 << v, v, n, 0);
    send_note(on, n);
    drain();
  endtask

  task automatic tick(input int exp_q, input int exp_mix);
    @(posedge clk); #1;
    sample_tick = 1'b1;
    tcyc = cyc;
    push_exp(K_MIX, exp_mix, 0, 0, tcyc + 9);
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(negedge clk);
    chk("query_sine", query_sine, exp_q);
    @(negedge clk);
    chk("query_one_cycle", query_sine, 0);
    drain();
  endtask

  initial begin
    nb.note_valid = 1'b0; nb.note_on = 1'b0; nb.note = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mix_valid", mix_valid, 0);
    chk("rst_change_note", change_note, 0);
    chk("rst_query_sine", query_sine, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_note_drop", note_drop, 0);
    chk("rst_mix_out", mix_out, 0);
    chk("rst_voice_note", voice_note, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", nb.note_ready, 1);

    // Allocation: lowest free voice, one pulse each.
    note_chg(1, 60, 0);
    note_chg(1, 64, 1);
    note_chg(1, 67, 2);
    set_sine(100, -300, 50, 7777);
    tick(4'b0111, -150);

    // Note-off frees voice 1; unknown note-off is ignored.
    send_note(0, 64); drain();
    tick(4'b0101, 150);
    send_note(0, 50); drain();
    tick(4'b0101, 150);

    // Voices 0 and 1 active: 100 + (-300).
    send_note(0, 67); drain();
    note_chg(1, 64, 1);
    tick(4'b0011, -200);

    // Retrigger of an active note: pulse only, no new voice.
    note_chg(1, 60, 0);
    tick(4'b0011, -200);

    // Fill all voices, then a fifth note-on.
    note_chg(1, 67, 2);
    note_chg(1, 72, 3);
`ifdef VOICE_STEAL_EN
    note_chg(1, 76, 0);
`else
    push_exp(K_DRP, 1, 0, 0, 0);
    send_note(1, 76);
    drain();
`endif

    // Sign extension and full-scale sums.
    set_sine(100, -300, 50, -8388608);
    tick(4'b1111, -8388758);
    set_sine(-8388608, -8388608, -8388608, -8388608);
    tick(4'b1111, -33554432);
    set_sine(8388607, 8388607, 8388607, 8388607);
    tick(4'b1111, 33554428);

    // Tick and event together: mix first, event afterwards; tick in WAIT overruns.
    set_sine(1, 2, 3, 4);
    @(posedge clk); #1;
    sample_tick = 1'b1;
    nb.note_valid = 1'b1; nb.note_on = 1'b0; nb.note = 7'd72;
    tcyc = cyc;
    push_exp(K_MIX, 10, 0, 0, tcyc + 9);
    @(negedge clk);
    chk("ready_low_on_tick", nb.note_ready, 0);
    @(posedge clk); #1 sample_tick = 1'b0;
    @(negedge clk);
    chk("overrun_before", overrun, 0);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      if (nb.note_ready) begin acc = cyc; break; end
      @(negedge clk);
    end
    @(posedge clk); #1 nb.note_valid = 1'b0;
    chk("accept_after_mix", acc, tcyc + 10);
    drain();
    tick(4'b0111, 6);
    chk("overrun_sticky", overrun, 1);

    // Reset in the middle of ACCUM aborts the mix and clears the voices.
    set_sine(5, 6, 7, 8);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", nb.note_ready, 1);
    chk("abort_mix_out", mix_out, 0);
    chk("abort_voice_note", voice_note, 0);
    chk("abort_overrun", overrun, 0);
    repeat (6) @(posedge clk);
    tick(4'b0000, 0);

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_voice_scheduler
`default_nettype wire
